// File: rtl/fft_frame_sequencer_if.sv
// Go/busy handshake bundle between the frame sequencer and its three stage engines.
// master = sequencer side (drives go), slave = engine side (drives busy).
interface fft_frame_sequencer_if;
    logic axis_bram_slave_go;
    logic axis_bram_slave_busy;
    logic fft_go;
    logic fft_busy;
    logic axis_bram_master_go;
    logic axis_bram_master_busy;

    modport master (
        output axis_bram_slave_go,
        output fft_go,
        output axis_bram_master_go,
        input  axis_bram_slave_busy,
        input  fft_busy,
        input  axis_bram_master_busy
    );

    modport slave (
        input  axis_bram_slave_go,
        input  fft_go,
        input  axis_bram_master_go,
        output axis_bram_slave_busy,
        output fft_busy,
        output axis_bram_master_busy
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the FFT pipeline: load -> compute -> unload, with go/busy
// handshakes to each engine, a wrapping frame counter, continuous streaming with
// a deferred stop, and a per-state watchdog that parks the sequencer in ERROR.
module fft_frame_sequencer #(
    parameter int TIMEOUT_CYCLES  = 1048576,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       continuous,
    input  logic                       stop,
    input  logic                       clear_err,
    output logic                       ctrl_busy,
    output logic [1:0]                 stage,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       timeout_err,
    fft_frame_sequencer_if.master      eng
);

    // Watchdog must be able to hold TIMEOUT_CYCLES-1.
    localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_GO,
        LOAD_WAIT,
        FFT_GO,
        FFT_WAIT,
        UNLOAD_GO,
        UNLOAD_WAIT,
        ERROR
    } state_t;

    state_t              state, state_nx;
    logic [WDOG_W-1:0]   wdog;
    logic                stop_pend;
    logic                in_stage;
    logic                done_fire;
    logic                to_fire;

    // Any GO/WAIT state is watched; IDLE and ERROR are not.
    assign in_stage  = (state != IDLE) && (state != ERROR);
    assign ctrl_busy = (state != IDLE);

    // Go lines are pure decodes of the state register, so they never glitch on busy.
    assign eng.axis_bram_slave_go  = (state == LOAD_GO);
    assign eng.fft_go              = (state == FFT_GO);
    assign eng.axis_bram_master_go = (state == UNLOAD_GO);

    // Stage number reported to software; ERROR reads as 0 like IDLE.
    always_comb begin
        stage = 2'd0;
        case (state)
            LOAD_GO, LOAD_WAIT:     stage = 2'd1;
            FFT_GO, FFT_WAIT:       stage = 2'd2;
            UNLOAD_GO, UNLOAD_WAIT: stage = 2'd3;
            default:                stage = 2'd0;
        endcase
    end

    // Next-state: advance on busy edges, loop or idle after unload, watchdog overrides.
    always_comb begin
        state_nx  = state;
        done_fire = 1'b0;
        to_fire   = 1'b0;
        case (state)
            IDLE:        if (start) state_nx = LOAD_GO;
            LOAD_GO:     if (eng.axis_bram_slave_busy) state_nx = LOAD_WAIT;
            LOAD_WAIT:   if (!eng.axis_bram_slave_busy) state_nx = FFT_GO;
            FFT_GO:      if (eng.fft_busy) state_nx = FFT_WAIT;
            FFT_WAIT:    if (!eng.fft_busy) state_nx = UNLOAD_GO;
            UNLOAD_GO:   if (eng.axis_bram_master_busy) state_nx = UNLOAD_WAIT;
            UNLOAD_WAIT: begin
                if (!eng.axis_bram_master_busy) begin
                    done_fire = 1'b1;
                    state_nx  = (continuous && !stop_pend && !stop) ? LOAD_GO : IDLE;
                end
            end
            ERROR:       if (clear_err) state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
        // A stage that has overstayed its budget is abandoned, even on its last cycle.
        if (in_stage && (wdog == WDOG_LAST)) begin
            state_nx  = ERROR;
            to_fire   = 1'b1;
            done_fire = 1'b0;
        end
    end

    // State, watchdog, frame bookkeeping and sticky flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wdog        <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            timeout_err <= 1'b0;
            stop_pend   <= 1'b0;
        end else begin
            state <= state_nx;

            if ((state_nx != state) || !in_stage)
                wdog <= '0;
            else
                wdog <= wdog + WDOG_W'(1);

            frame_done <= done_fire;
            if (done_fire)
                frame_count <= frame_count + FRAME_CNT_WIDTH'(1);

            if (to_fire)
                timeout_err <= 1'b1;
            else if ((state == ERROR) && clear_err)
                timeout_err <= 1'b0;

            // Start beats a simultaneous stop; stop is only remembered once running.
            if ((state == IDLE) && start)
                stop_pend <= 1'b0;
            else if ((state != IDLE) && stop)
                stop_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized bench for fft_frame_sequencer. The bench plays the three engines with
// random go->busy delays and busy lengths and predicts every handshake cycle, the
// frame_done pulses, the wrapping frame count and the loop/stop decision from the
// frame-level rules. Directed sections cover watchdog expiry and mid-frame reset.
module tb_fft_frame_sequencer;

    localparam int TO  = 64;
    localparam int FCW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           continuous;
    logic           stop;
    logic           clear_err;
    logic           ctrl_busy;
    logic [1:0]     stage;
    logic           frame_done;
    logic [FCW-1:0] frame_count;
    logic           timeout_err;

    fft_frame_sequencer_if eng ();

    fft_frame_sequencer #(
        .TIMEOUT_CYCLES  (TO),
        .FRAME_CNT_WIDTH (FCW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .continuous  (continuous),
        .stop        (stop),
        .clear_err   (clear_err),
        .ctrl_busy   (ctrl_busy),
        .stage       (stage),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .timeout_err (timeout_err),
        .eng         (eng)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int fcnt = 0;
    int stop_at = -1;
    bit stop_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic go_of(input int w);
        case (w)
            0:       return eng.axis_bram_slave_go;
            1:       return eng.fft_go;
            default: return eng.axis_bram_master_go;
        endcase
    endfunction

    task automatic set_busy(input int w, input logic v);
        case (w)
            0:       eng.axis_bram_slave_busy  = v;
            1:       eng.fft_busy              = v;
            default: eng.axis_bram_master_busy = v;
        endcase
    endtask

    // One clock: drive the planned stop pulse, then land on the next falling edge.
    task automatic cyc();
        stop = (fcnt == stop_at);
        if (stop) stop_seen = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        fcnt++;
    endtask

    // Play engine w: raise busy r cycles after go appears, hold it for L cycles.
    task automatic stage_run(input int w, input int r, input int L);
        chk("go_on", go_of(w), 1);
        chk("stage_go", stage, w + 1);
        for (int i = 1; i < r; i++) begin
            cyc();
            chk("go_hold", go_of(w), 1);
        end
        set_busy(w, 1'b1);
        cyc();
        chk("go_drop", {eng.axis_bram_slave_go, eng.fft_go, eng.axis_bram_master_go}, 0);
        chk("stage_wait", stage, w + 1);
        chk("busy_wait", ctrl_busy, 1);
        for (int i = 1; i < L; i++) begin
            cyc();
            chk("go_quiet", {eng.axis_bram_slave_go, eng.fft_go, eng.axis_bram_master_go}, 0);
        end
        set_busy(w, 1'b0);
        cyc();
    endtask

    task automatic run_frame(output bit looped);
        for (int w = 0; w < 3; w++)
            stage_run(w, $urandom_range(1, 5), $urandom_range(1, 40));
        exp_cnt = (exp_cnt + 1) % (1 << FCW);
        looped  = continuous && !stop_seen;
        chk("frame_done", frame_done, 1);
        chk("frame_count", frame_count, exp_cnt);
        if (looped) begin
            chk("loop_stage", stage, 1);
            chk("loop_go", eng.axis_bram_slave_go, 1);
            cyc();
            chk("done_pulse", frame_done, 0);
            chk("loop_go2", eng.axis_bram_slave_go, 1);
        end else begin
            chk("idle_busy", ctrl_busy, 0);
            chk("idle_stage", stage, 0);
            chk("idle_go", eng.axis_bram_slave_go, 0);
            cyc();
            chk("done_pulse", frame_done, 0);
            chk("idle_busy2", ctrl_busy, 0);
        end
    endtask

    // One start..idle run; optional random stop, forced stop after the 4th looped frame.
    task automatic run_seq(input bit cont, input bit both, input bit rand_stop);
        bit looped;
        continuous = cont;
        stop_seen  = 1'b0;
        chk("pre_idle", ctrl_busy, 0);
        start = 1'b1;
        stop  = both;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        fcnt    = 0;
        stop_at = (cont && rand_stop) ? int'($urandom_range(0, 250)) : -1;
        looped  = 1'b1;
        for (int nf = 1; nf <= 8 && looped; nf++) begin
            run_frame(looped);
            if (nf == 4 && looped) stop_at = fcnt;
        end
        chk("run_ends", looped, 0);
        stop_at = -1;
        continuous = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; continuous = 1'b0; stop = 1'b0; clear_err = 1'b0;
        eng.axis_bram_slave_busy = 1'b0; eng.fft_busy = 1'b0; eng.axis_bram_master_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", ctrl_busy, 0);
        chk("rst_stage", stage, 0);
        chk("rst_cnt", frame_count, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_go", {eng.axis_bram_slave_go, eng.fft_go, eng.axis_bram_master_go}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single frame, then a directed 5-frame continuous run across the counter wrap.
        run_seq(1'b0, 1'b0, 1'b0);
        run_seq(1'b1, 1'b0, 1'b0);
        // Start together with stop: start wins, streaming continues.
        run_seq(1'b1, 1'b1, 1'b0);
        // Random mix.
        for (int k = 0; k < 14; k++)
            run_seq(1'(($urandom % 2)), 1'(($urandom % 2)), 1'b1);

        // Watchdog: load engine never answers go.
        start = 1'b1; @(negedge clk); start = 1'b0;
        n = 0;
        while (eng.axis_bram_slave_go && n < 200) begin n++; @(negedge clk); end
        chk("to_go_cycles", n, TO);
        chk("to_go_err", timeout_err, 1);
        chk("to_go_busy", ctrl_busy, 1);
        chk("to_go_stage", stage, 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("err_ignores_start", {ctrl_busy, stage, eng.axis_bram_slave_go}, 4'b1000);
        clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
        chk("clr_busy", ctrl_busy, 0);
        chk("clr_err", timeout_err, 0);

        // Watchdog: FFT busy stuck high.
        start = 1'b1; @(negedge clk); start = 1'b0;
        stage_run(0, 2, 3);
        chk("fft_go_on", eng.fft_go, 1);
        eng.fft_busy = 1'b1;
        @(negedge clk);
        n = 0;
        while (stage == 2'd2 && n < 200) begin n++; @(negedge clk); end
        chk("to_fft_cycles", n, TO);
        chk("to_fft_err", timeout_err, 1);
        chk("to_fft_go", eng.fft_go, 0);
        eng.fft_busy = 1'b0;
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        chk("to_fft_hold", {ctrl_busy, stage, timeout_err}, 4'b1001);
        chk("to_fft_cnt", frame_count, exp_cnt);
        clear_err = 1'b1; @(negedge clk); clear_err = 1'b0;
        chk("clr2_busy", ctrl_busy, 0);
        chk("clr2_err", timeout_err, 0);
        run_seq(1'b0, 1'b0, 1'b0);

        // Reset in the middle of LOAD_WAIT.
        start = 1'b1; @(negedge clk); start = 1'b0;
        eng.axis_bram_slave_busy = 1'b1;
        repeat (3) @(negedge clk);
        chk("lw_stage", stage, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_busy", ctrl_busy, 0);
        chk("mr_stage", stage, 0);
        chk("mr_cnt", frame_count, 0);
        chk("mr_err", timeout_err, 0);
        chk("mr_go", {eng.axis_bram_slave_go, eng.fft_go, eng.axis_bram_master_go, frame_done}, 0);
        reset = 1'b1;
        eng.axis_bram_slave_busy = 1'b0;
        exp_cnt = 0;
        @(negedge clk);
        run_seq(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
